// File: rtl/regfile_debug_port_if.sv
// Bundle between the register-file debug engine and its surroundings: register-file
// select/write lines plus the outbound dump stream and the inbound load stream.
interface regfile_debug_port_if #(
    parameter int NREGS = 32,
    parameter int DW    = 32
);
    localparam int IW = $clog2(NREGS);

    logic [IW-1:0] rf_rsel;
    logic [DW-1:0] rf_rdat;
    logic          rf_WEN;
    logic [IW-1:0] rf_wsel;
    logic [DW-1:0] rf_wdat;

    logic          dout_valid;
    logic          dout_ready;
    logic [DW-1:0] dout_data;
    logic          dout_last;

    logic          din_valid;
    logic          din_ready;
    logic [DW-1:0] din_data;

    // master is the debug engine; slave is the register file plus the stream endpoints
    modport master (
        output rf_rsel, rf_WEN, rf_wsel, rf_wdat,
        input  rf_rdat,
        output dout_valid, dout_data, dout_last,
        input  dout_ready,
        input  din_valid, din_data,
        output din_ready
    );

    modport slave (
        input  rf_rsel, rf_WEN, rf_wsel, rf_wdat,
        output rf_rdat,
        input  dout_valid, dout_data, dout_last,
        output dout_ready,
        output din_valid, din_data,
        input  din_ready
    );
endinterface

// File: rtl/regfile_debug_port.sv
// Debug access engine for the CPU register file: while the core is halted it either
// streams every register out (dump) or writes registers 1..NREGS-1 from a stream (load).
module regfile_debug_port #(
    parameter int NREGS = 32,
    parameter int DW    = 32
) (
    input  logic CLK,
    input  logic nRST,
    input  logic halt,
    input  logic start_dump,
    input  logic start_load,
    output logic busy,
    output logic done,
    output logic abort,
    regfile_debug_port_if.master dbg
);
    localparam int            IW       = $clog2(NREGS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NREGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DUMP_RD,
        S_DUMP_TX,
        S_LOAD,
        S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic [DW-1:0] dout_q, dout_nxt;
    logic          at_last;

    assign at_last       = (idx == LAST_IDX);
    assign dbg.dout_data = dout_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= S_IDLE;
            idx    <= '0;
            dout_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            state  <= state_nxt;
            idx    <= idx_nxt;
            dout_q <= dout_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first; a missed path would otherwise infer a latch.
        state_nxt      = state;
        idx_nxt        = idx;
        dout_nxt       = dout_q;
        busy           = (state != S_IDLE);
        done           = 1'b0;
        abort          = 1'b0;
        dbg.rf_rsel    = '0;
        dbg.rf_WEN     = 1'b0;
        dbg.rf_wsel    = '0;
        dbg.rf_wdat    = '0;
        dbg.dout_valid = 1'b0;
        dbg.dout_last  = 1'b0;
        dbg.din_ready  = 1'b0;

        unique case (state)
            S_IDLE: begin
                // dump has priority when both starts arrive together
                if (halt && start_dump) begin
                    state_nxt = S_DUMP_RD;
                    idx_nxt   = '0;
                end else if (halt && start_load) begin
                    state_nxt = S_LOAD;
                    idx_nxt   = IW'(1);
                end
            end

            S_DUMP_RD: begin
                dbg.rf_rsel = idx;
                if (!halt) begin
                    abort     = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    dout_nxt  = dbg.rf_rdat;
                    state_nxt = S_DUMP_TX;
                end
            end

            S_DUMP_TX: begin
                if (!halt) begin
                    abort     = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    dbg.dout_valid = 1'b1;
                    dbg.dout_last  = at_last;
                    if (dbg.dout_ready) begin
                        if (at_last) begin
                            state_nxt = S_DONE;
                        end else begin
                            idx_nxt   = idx + IW'(1);
                            state_nxt = S_DUMP_RD;
                        end
                    end
                end
            end

            S_LOAD: begin
                if (!halt) begin
                    abort     = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    dbg.din_ready = 1'b1;
                    if (dbg.din_valid) begin
                        dbg.rf_WEN  = 1'b1;
                        dbg.rf_wsel = idx;
                        dbg.rf_wdat = dbg.din_data;
                        if (at_last) state_nxt = S_DONE;
                        else         idx_nxt   = idx + IW'(1);
                    end
                end
            end

            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end

            default: state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: doc/regfile_debug_port.md
# regfile_debug_port

Debug-side access engine for the 32-entry CPU register file. While the core is halted, it either dumps every register out over a valid/ready stream, or loads registers 1..31 from an inbound valid/ready stream. It sits beside the datapath and drives the register file's read-select and write ports. The core's own drivers are muxed off by top-level glue whenever `busy` is high.

## Interface
Parameters:
- `NREGS`, 32: number of architectural registers; index width is clog2(NREGS).
- `DW`, 32: register/word width.

Ports:
- `CLK`  in  1  system clock, rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `halt`  in  1  core halted; the engine may start or continue only while this is high.
- `start_dump`  in  1  request a full register dump (sampled only in IDLE).
- `start_load`  in  1  request a register load (sampled only in IDLE).
- `rf_rsel`  out  5  register file read select.
- `rf_rdat`  in  DW  register file read data; combinational from `rf_rsel`.
- `rf_WEN`  out  1  register file write enable.
- `rf_wsel`  out  5  register file write select.
- `rf_wdat`  out  DW  register file write data.
- `dout_valid`  out  1  dump word valid.
- `dout_ready`  in  1  dump sink ready.
- `dout_data`  out  DW  dump word.
- `dout_last`  out  1  high with the word for register NREGS-1.
- `din_valid`  in  1  load word valid.
- `din_ready`  out  1  engine ready for a load word.
- `din_data`  in  DW  load word.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse on normal completion.
- `abort`  out  1  one-cycle pulse when `halt` drops mid-operation.

## Operation
- **States:** IDLE, DUMP_RD, DUMP_TX, LOAD, DONE. The state, a 5-bit index `idx`, and the `dout_data` register are the only storage.
- **Leaving IDLE:**
  - With `halt` high: `start_dump` leads to DUMP_RD with idx=0; otherwise `start_load` leads to LOAD with idx=1.
  - If both starts are high, the dump wins.
  - With `halt` low, both starts are ignored.
- **DUMP_RD:**
  - `rf_rsel`=idx.
  - `dout_data` captures `rf_rdat` at the clock edge; next state is DUMP_TX.
- **DUMP_TX:**
  - `dout_valid`=1; `dout_data` and `dout_last` are held stable until the handshake.
  - `dout_last`=(idx==NREGS-1).
  - On `dout_valid`&&`dout_ready`: if idx==NREGS-1 go to DONE; else idx+1 and go to DUMP_RD.
  - Register 0 is dumped; it reads as 0.
- **LOAD:**
  - `din_ready`=1.
  - On `din_valid`, in the same cycle: `rf_WEN`=1, `rf_wsel`=idx, `rf_wdat`=`din_data`.
  - If idx==NREGS-1 go to DONE; else idx+1.
  - Register 0 is never written; exactly NREGS-1 words are accepted.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **Abort:** `halt` low in DUMP_RD, DUMP_TX or LOAD goes to IDLE next cycle with `abort`=1 in that same (abort-detecting) cycle. In that cycle:
  - `rf_WEN`=0 and `din_ready`=0, so no write occurs.
  - `dout_valid`=0; a pending dump word is dropped.
- **Idle outputs:** outside the states above, `rf_WEN`, `din_ready`, `dout_valid` and `dout_last` are 0. `rf_wsel`, `rf_wdat` and `rf_rsel` are 0 except where defined above.

## Timing
- **Reset:** state IDLE, idx=0, `dout_data`=0. All outputs are 0, including `rf_rsel`.
- **Reset mid-operation:** immediate return to IDLE with reset values; no `done` or `abort` pulse.
- **Dump latency:**
  - Start sampled in IDLE at edge N; DUMP_RD during cycle N+1; `dout_valid` high from cycle N+2.
  - Each word takes at least 2 cycles (DUMP_RD then DUMP_TX), so a full dump takes 64 cycles minimum with `dout_ready` held high.
  - `done` is high one cycle after the final handshake.
- **Load:**
  - `din_ready` is high from the cycle after the start is sampled; one word per cycle is accepted.
  - The register file updates at the edge ending the accept cycle.
  - A full load takes at least 31 cycles; `done` follows the final accept by one cycle.
- `busy` covers every non-IDLE cycle, including DONE.
- New starts are accepted only in IDLE, which is at least one cycle after DONE.

## Test plan
- **Dump after reset:** preload reg k = 0x1000_0000+k via the core path, then `start_dump` with `dout_ready`=1 → 32 words in order: 0x0, 0x1000_0001 .. 0x1000_001F. `dout_last` only on the 32nd word, then one `done` pulse; valid→valid spacing is exactly 2 cycles.
- **Dump backpressure:** toggle `dout_ready` pseudo-randomly → `dout_data` and `dout_last` stay stable while valid && !ready; no word is lost or duplicated.
- **Load then dump:** `start_load` streaming 0xA5A5_0001..0xA5A5_001F with gaps in `din_valid` → exactly 31 accepts, `rf_wsel` 1..31. The following dump returns 0 for reg 0 and the loaded values for regs 1..31.
- **Simultaneous starts:** `start_dump` and `start_load` both high → dump runs; `din_ready` stays 0. With `halt`=0, starts → `busy` stays 0.
- **Abort:** drop `halt` after 10 load accepts → `abort` pulse, no `done`, `rf_WEN` never high afterward. Regs 1..10 hold the new values, regs 11..31 are unchanged.
- **Reset mid-dump:** assert `nRST` low while in DUMP_TX → `dout_valid`, `busy` and `rf_rsel` go to 0 asynchronously. The next `start_dump` restarts from reg 0.
